stopwatch_time_core: RTL and testbench
======================================

Name: stopwatch_time_core

Overview:
Downstream consumer of the tick generator's one-cycle threshold pulse. It is configured for a 100 Hz tick, so one tick equals one hundredth of a second. It counts elapsed time as BCD digits MM:SS.hh under start/stop, clear and lap control. It feeds the seven-segment display multiplexer. Control inputs are already debounced, single-cycle pulses from the button conditioning stage.

Parameters:
MAX_MINUTES, 99, highest minute value reached before overflow; legal range 1..99.
WRAP_ON_OVERFLOW, 0, 0 = saturate and pause at the maximum; 1 = roll over to 00:00.00 and keep running.

Ports:
clk  in  1  system clock (100 MHz board clock)
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse, one per hundredth of a second
start_stop  in  1  pulse; toggles between running and paused
clear  in  1  pulse; zeroes the time and returns to IDLE
lap  in  1  pulse; toggles the display freeze
min_tens, min_ones  out  4 each  BCD minutes shown on the display
sec_tens, sec_ones  out  4 each  BCD seconds shown on the display
hun_tens, hun_ones  out  4 each  BCD hundredths shown on the display
running  out  1  high while state is RUNNING
lap_frozen  out  1  high while the display is frozen
overflow  out  1  sticky; set when the maximum time is passed

Behaviour:
- Reset: all count digits 0, all display digits 0, state IDLE, running=0, lap_frozen=0, overflow=0. A reset mid-run discards everything.
- States and transitions:
  - IDLE: start_stop goes to RUNNING.
  - RUNNING: start_stop goes to PAUSED.
  - PAUSED: start_stop goes to RUNNING.
  - clear from any state goes to IDLE.
- Input priority in one cycle: rst > clear > start_stop/tick > lap.
- Counting: on tick, the count increments only if the current state (the registered state before this edge) is RUNNING.
  - A tick in the same cycle as a start out of IDLE or PAUSED is not counted.
  - A tick in the same cycle as a stop out of RUNNING is counted.
- Digit chain: hun_ones 0-9 carries into hun_tens 0-9, then sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-9.
  - Each carry is combinational within the same edge; there is no multi-cycle ripple.
- Maximum count is MAX_MINUTES:59.99. A tick at the maximum:
  - WRAP_ON_OVERFLOW=0: the count holds, overflow is set to 1, and the state goes to PAUSED. start_stop from PAUSED then resumes and immediately saturates again on the next tick.
  - WRAP_ON_OVERFLOW=1: the count goes to 00:00.00, overflow is set to 1, and the state stays RUNNING.
- clear: zeroes the count and display, sets overflow=0 and lap_frozen=0, goes to IDLE. Any tick in the same cycle is ignored.
- Display:
  - When lap_frozen=0, the display registers load the next count value on the same edge as the counter. The display therefore equals the count with zero added latency.
  - When lap_frozen=1, the display holds while the count continues.
- lap:
  - In RUNNING: toggles lap_frozen. On release, the display loads the live count on that same edge.
  - In PAUSED: only releases a freeze (1 to 0); it never sets one.
  - In IDLE: ignored.
- running = (state == RUNNING), registered.
- Outputs never hold non-BCD values. Digit registers only load values from the legal set.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding IDLE/RUNNING/PAUSED (2 bits);
  - the BCD digit width 4;
  - the constants DIGIT_MAX_DEC=9 and DIGIT_MAX_SEX=5;
  - the 100 Hz tick rate, used by the instantiating top to set the tick generator's output frequency.
- One sub-module, bcd_digit_counter:
  - parameter: digit modulus;
  - inputs: clk, rst, clr, inc, load-zero;
  - outputs: digit, carry_out (inc && digit==max).
  - Six instances are chained. The minute digits are limited against MAX_MINUTES by the top's saturation logic.

Test Plan:
- Reset then 5 ticks with no start -> all digits 0, running=0.
- Pulse start_stop, then 1234 ticks -> display 00:12.34, running=1. A tick coincident with the start pulse is not counted.
- From 00:59.99 while running, 1 tick -> 01:00.00 in the same cycle, with all carries resolved.
- Lap at 00:05.00, 300 more ticks -> display stays 00:05.00 with lap_frozen=1. A second lap -> display 00:08.00 on that edge.
- MAX_MINUTES=1, WRAP=0, run to 01:59.99, 1 tick -> display holds 01:59.99, overflow=1, state PAUSED. With WRAP=1 -> 00:00.00, overflow=1, running=1.
- Simultaneous clear+start_stop+tick while RUNNING at 00:03.21 -> 00:00.00, IDLE, overflow=0. Then rst mid-run -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time core: state encoding,
// BCD digit limits and the single-digit step helper used by counter and display paths.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX_DEC = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_SEX = 4'd5;

  // Tick rate the instantiating top programs into the tick generator.
  localparam int TICK_HZ = 100;

  function automatic logic [DIGIT_W-1:0] bcd_next(
    input logic [DIGIT_W-1:0] d,
    input logic               inc,
    input logic               zero,
    input logic [DIGIT_W-1:0] dmax
  );
    logic [DIGIT_W-1:0] r;
    r = d;
    if (zero)
      r = '0;
    else if (inc)
      r = (d == dmax) ? '0 : d + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_time_core_bcd_digit_counter.sv
// Single BCD digit counting 0..MODULUS-1; carry_out is combinational so a
// chain of digits settles within one edge.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic               load_zero,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MODULUS - 1);

  assign carry_out = inc && (digit == DIGIT_MAX);

  always_ff @(posedge clk) begin
    if (rst)
      digit <= '0;
    else
      digit <= bcd_next(digit, inc, clr || load_zero, DIGIT_MAX);
  end

endmodule

// File: rtl/stopwatch_time_core.sv
// MM:SS.hh stopwatch driven by a 100 Hz tick, with start/stop, clear,
// lap freeze and saturate-or-wrap behaviour at MAX_MINUTES:59.99.
//
// state   | meaning
// IDLE    | cleared, waiting for first start
// RUNNING | counting ticks
// PAUSED  | stopped by user or by saturation, count held
module stopwatch_time_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MINUTES      = 99,
  parameter bit          WRAP_ON_OVERFLOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] hun_tens,
  output logic [3:0] hun_ones,
  output logic       running,
  output logic       lap_frozen,
  output logic       overflow
);

  localparam logic [DIGIT_W-1:0] MAX_MIN_TENS = DIGIT_W'(MAX_MINUTES / 10);
  localparam logic [DIGIT_W-1:0] MAX_MIN_ONES = DIGIT_W'(MAX_MINUTES % 10);

  state_t state;

  logic [DIGIT_W-1:0] c_ho, c_ht, c_so, c_st, c_mo, c_mt;
  logic               cy_ho, cy_ht, cy_so, cy_st, cy_mo, cy_mt;
  logic               at_max, count_en, inc_chain, wrap_zero, zero_cnt;
  logic               sat_hit, ovf_hit, lap_release;

  assign at_max = (c_mt == MAX_MIN_TENS)  && (c_mo == MAX_MIN_ONES) &&
                  (c_st == DIGIT_MAX_SEX) && (c_so == DIGIT_MAX_DEC) &&
                  (c_ht == DIGIT_MAX_DEC) && (c_ho == DIGIT_MAX_DEC);

  assign count_en  = tick && (state == RUNNING) && !clear;
  assign inc_chain = count_en && !at_max;
  assign wrap_zero = count_en && at_max && WRAP_ON_OVERFLOW;
  assign zero_cnt  = clear || wrap_zero;
  assign sat_hit   = count_en && at_max && !WRAP_ON_OVERFLOW;
  // A carry out of the top digit would mean the limit compare was bypassed.
  assign ovf_hit   = (count_en && at_max) || cy_mt;

  assign lap_release = lap && lap_frozen && ((state == RUNNING) || (state == PAUSED));

  bcd_digit_counter #(.MODULUS(10)) u_hun_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(inc_chain), .load_zero(wrap_zero),
    .digit(c_ho), .carry_out(cy_ho));
  bcd_digit_counter #(.MODULUS(10)) u_hun_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(cy_ho), .load_zero(wrap_zero),
    .digit(c_ht), .carry_out(cy_ht));
  bcd_digit_counter #(.MODULUS(10)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(cy_ht), .load_zero(wrap_zero),
    .digit(c_so), .carry_out(cy_so));
  bcd_digit_counter #(.MODULUS(6)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(cy_so), .load_zero(wrap_zero),
    .digit(c_st), .carry_out(cy_st));
  bcd_digit_counter #(.MODULUS(10)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(cy_st), .load_zero(wrap_zero),
    .digit(c_mo), .carry_out(cy_mo));
  bcd_digit_counter #(.MODULUS(10)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(cy_mo), .load_zero(wrap_zero),
    .digit(c_mt), .carry_out(cy_mt));

  // Display mirrors the counter's next value so it shows the count with no added latency.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      hun_tens <= '0;
      hun_ones <= '0;
    end else if (!lap_frozen || lap_release) begin
      hun_ones <= bcd_next(c_ho, inc_chain, zero_cnt, DIGIT_MAX_DEC);
      hun_tens <= bcd_next(c_ht, cy_ho,     zero_cnt, DIGIT_MAX_DEC);
      sec_ones <= bcd_next(c_so, cy_ht,     zero_cnt, DIGIT_MAX_DEC);
      sec_tens <= bcd_next(c_st, cy_so,     zero_cnt, DIGIT_MAX_SEX);
      min_ones <= bcd_next(c_mo, cy_st,     zero_cnt, DIGIT_MAX_DEC);
      min_tens <= bcd_next(c_mt, cy_mo,     zero_cnt, DIGIT_MAX_DEC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= IDLE;
      running    <= 1'b0;
      overflow   <= 1'b0;
      lap_frozen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_stop) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        RUNNING: begin
          if (start_stop || sat_hit) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
          if (lap)
            lap_frozen <= !lap_frozen;
        end
        PAUSED: begin
          if (start_stop) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
          if (lap)
            lap_frozen <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
      if (ovf_hit)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed bench for stopwatch_time_core: one default instance plus two
// MAX_MINUTES=1 instances (saturate and wrap) sharing the same stimulus.
module tb_stopwatch_time_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  logic [3:0] a_mt, a_mo, a_st, a_so, a_ht, a_ho;
  logic [3:0] b_mt, b_mo, b_st, b_so, b_ht, b_ho;
  logic [3:0] c_mt, c_mo, c_st, c_so, c_ht, c_ho;
  logic a_run, a_lap, a_ovf, b_run, b_lap, b_ovf, c_run, c_lap, c_ovf;
  logic [23:0] a_disp, b_disp, c_disp;

  assign a_disp = {a_mt, a_mo, a_st, a_so, a_ht, a_ho};
  assign b_disp = {b_mt, b_mo, b_st, b_so, b_ht, b_ho};
  assign c_disp = {c_mt, c_mo, c_st, c_so, c_ht, c_ho};

  stopwatch_time_core u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .hun_tens(a_ht), .hun_ones(a_ho), .running(a_run), .lap_frozen(a_lap), .overflow(a_ovf));

  stopwatch_time_core #(.MAX_MINUTES(1), .WRAP_ON_OVERFLOW(1'b0)) u_dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .hun_tens(b_ht), .hun_ones(b_ho), .running(b_run), .lap_frozen(b_lap), .overflow(b_ovf));

  stopwatch_time_core #(.MAX_MINUTES(1), .WRAP_ON_OVERFLOW(1'b1)) u_dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_tens(c_mt), .min_ones(c_mo), .sec_tens(c_st), .sec_ones(c_so),
    .hun_tens(c_ht), .hun_ones(c_ho), .running(c_run), .lap_frozen(c_lap), .overflow(c_ovf));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
    tick = t;
    start_stop = ss;
    clear = cl;
    lap = lp;
    @(posedge clk);
    #1;
    tick = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_disp", a_disp, 24'h000000);
    check_val("reset_run", a_run, 1'b0);
    check_val("reset_lap", a_lap, 1'b0);
    check_val("reset_ovf", a_ovf, 1'b0);

    run_ticks(5);
    check_val("idle_ticks_disp", a_disp, 24'h000000);
    check_val("idle_ticks_run", a_run, 1'b0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("start_tick_ignored", a_disp, 24'h000000);
    check_val("start_run", a_run, 1'b1);
    run_ticks(1234);
    check_val("count_1234", a_disp, 24'h001234);
    check_val("count_run", a_run, 1'b1);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("clear_disp", a_disp, 24'h000000);
    check_val("clear_run", a_run, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("lap_idle_ignored", a_lap, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(500);
    check_val("count_500", a_disp, 24'h000500);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("lap_set", a_lap, 1'b1);
    check_val("lap_set_disp", a_disp, 24'h000500);
    run_ticks(300);
    check_val("lap_hold_disp", a_disp, 24'h000500);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("lap_release", a_lap, 1'b0);
    check_val("lap_release_disp", a_disp, 24'h000800);

    run_ticks(5199);
    check_val("count_5999", a_disp, 24'h005999);
    run_ticks(1);
    check_val("carry_minute", a_disp, 24'h010000);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("stop_tick_counted", a_disp, 24'h010001);
    check_val("stop_run", a_run, 1'b0);
    run_ticks(1);
    check_val("paused_tick_ignored", a_disp, 24'h010001);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("paused_lap_no_set", a_lap, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(10);
    check_val("frozen_before_pause", a_disp, 24'h010001);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("paused_lap_release", a_lap, 1'b0);
    check_val("paused_release_disp", a_disp, 24'h010011);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(321);
    check_val("count_321", a_disp, 24'h000321);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("clear_combo_disp", a_disp, 24'h000000);
    check_val("clear_combo_run", a_run, 1'b0);
    check_val("clear_combo_ovf", a_ovf, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(50);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("pre_rst_lap", a_lap, 1'b1);
    rst = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick = 1'b0;
    check_val("rst_mid_disp", a_disp, 24'h000000);
    check_val("rst_mid_run", a_run, 1'b0);
    check_val("rst_mid_lap", a_lap, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(11999);
    check_val("sat_pre_disp", b_disp, 24'h015999);
    check_val("wrap_pre_disp", c_disp, 24'h015999);
    check_val("sat_pre_ovf", b_ovf, 1'b0);
    run_ticks(1);
    check_val("dflt_past_1min59", a_disp, 24'h020000);
    check_val("dflt_no_ovf", a_ovf, 1'b0);
    check_val("sat_hold_disp", b_disp, 24'h015999);
    check_val("sat_ovf", b_ovf, 1'b1);
    check_val("sat_paused", b_run, 1'b0);
    check_val("wrap_disp", c_disp, 24'h000000);
    check_val("wrap_ovf", c_ovf, 1'b1);
    check_val("wrap_run", c_run, 1'b1);
    run_ticks(1);
    check_val("sat_paused_hold", b_disp, 24'h015999);
    check_val("wrap_continue", c_disp, 24'h000001);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("sat_resume", b_run, 1'b1);
    run_ticks(1);
    check_val("sat_again_disp", b_disp, 24'h015999);
    check_val("sat_again_run", b_run, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("sat_clear_ovf", b_ovf, 1'b0);
    check_val("wrap_clear_ovf", c_ovf, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
